// File: rtl/axi_rd_arbiter_2x1.sv
// axi_rd_arbiter_2x1: two-master to one-slave AXI read interconnect.
// AR requests are arbitrated round-robin into a registered AR stage whose
// slave-side ID carries the master index as its MSB. R beats return to the
// owning master by that MSB, and per-master outstanding-burst counters
// throttle each master at MAX_OUT.
// Optional feature macro: RD_ARB_ERRCHK_EN (unexpected-R detection/drain).
module axi_rd_arbiter_2x1 #(
  parameter int unsigned BusWidth = 32,
  parameter int unsigned TAGW     = 2,
  parameter int unsigned MAX_OUT  = 4
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  // master 0 AR
  input  logic [TAGW-2:0]     M0_ARID,
  input  logic [BusWidth-1:0] M0_ARADDR,
  input  logic [3:0]          M0_ARLEN,
  input  logic [1:0]          M0_ARSIZE,
  input  logic [1:0]          M0_ARBURST,
  input  logic [1:0]          M0_ARLOCK,
  input  logic [3:0]          M0_ARCACHE,
  input  logic [2:0]          M0_ARPROT,
  input  logic                M0_ARVALID,
  output logic                M0_ARREADY,
  // master 1 AR
  input  logic [TAGW-2:0]     M1_ARID,
  input  logic [BusWidth-1:0] M1_ARADDR,
  input  logic [3:0]          M1_ARLEN,
  input  logic [1:0]          M1_ARSIZE,
  input  logic [1:0]          M1_ARBURST,
  input  logic [1:0]          M1_ARLOCK,
  input  logic [3:0]          M1_ARCACHE,
  input  logic [2:0]          M1_ARPROT,
  input  logic                M1_ARVALID,
  output logic                M1_ARREADY,
  // slave AR
  output logic [TAGW-1:0]     S_ARID,
  output logic [BusWidth-1:0] S_ARADDR,
  output logic [3:0]          S_ARLEN,
  output logic [1:0]          S_ARSIZE,
  output logic [1:0]          S_ARBURST,
  output logic [1:0]          S_ARLOCK,
  output logic [3:0]          S_ARCACHE,
  output logic [2:0]          S_ARPROT,
  output logic                S_ARVALID,
  input  logic                S_ARREADY,
  // slave R
  input  logic [TAGW-1:0]     S_RID,
  input  logic [BusWidth-1:0] S_RDATA,
  input  logic [1:0]          S_RRESP,
  input  logic                S_RLAST,
  input  logic                S_RVALID,
  output logic                S_RREADY,
  // master 0 R
  output logic [TAGW-2:0]     M0_RID,
  output logic [BusWidth-1:0] M0_RDATA,
  output logic [1:0]          M0_RRESP,
  output logic                M0_RLAST,
  output logic                M0_RVALID,
  input  logic                M0_RREADY,
  // master 1 R
  output logic [TAGW-2:0]     M1_RID,
  output logic [BusWidth-1:0] M1_RDATA,
  output logic [1:0]          M1_RRESP,
  output logic                M1_RLAST,
  output logic                M1_RVALID,
  input  logic                M1_RREADY,
  output logic                err_unexp
);

  localparam logic [0:0] AR_IDLE = 1'b0;
  localparam logic [0:0] AR_SEND = 1'b1;

  logic [0:0]      ar_state;
  logic            last_grant;
  logic [1:0][2:0] out_cnt;
  logic            elig0, elig1, grant_any, grant_m;
  logic            ar_acc, r_done, sel, unexp;
  logic [1:0]      inc, dec;

  logic [TAGW-2:0]     pick_id;
  logic [BusWidth-1:0] pick_addr;
  logic [3:0]          pick_len, pick_cache;
  logic [1:0]          pick_size, pick_burst, pick_lock;
  logic [2:0]          pick_prot;

  // Eligibility and round-robin pick; only meaningful in AR_IDLE
  always_comb begin
    elig0     = M0_ARVALID && (out_cnt[0] < 3'(MAX_OUT));
    elig1     = M1_ARVALID && (out_cnt[1] < 3'(MAX_OUT));
    grant_any = (ar_state == AR_IDLE) && (elig0 || elig1);
    if (elig0 && elig1) grant_m = ~last_grant;
    else                grant_m = elig1;
  end

  // Master ARREADY depends only on state, ARVALID and counters, never on S_ARREADY
  always_comb begin
    M0_ARREADY = ARESETn && grant_any && !grant_m;
    M1_ARREADY = ARESETn && grant_any &&  grant_m;
  end

  // Payload mux for the granted master
  always_comb begin
    if (grant_m) begin
      pick_id    = M1_ARID;
      pick_addr  = M1_ARADDR;
      pick_len   = M1_ARLEN;
      pick_size  = M1_ARSIZE;
      pick_burst = M1_ARBURST;
      pick_lock  = M1_ARLOCK;
      pick_cache = M1_ARCACHE;
      pick_prot  = M1_ARPROT;
    end else begin
      pick_id    = M0_ARID;
      pick_addr  = M0_ARADDR;
      pick_len   = M0_ARLEN;
      pick_size  = M0_ARSIZE;
      pick_burst = M0_ARBURST;
      pick_lock  = M0_ARLOCK;
      pick_cache = M0_ARCACHE;
      pick_prot  = M0_ARPROT;
    end
  end

  assign S_ARVALID = (ar_state == AR_SEND);
  assign ar_acc    = S_ARVALID && S_ARREADY;

  // AR FSM and registered slave AR stage; the granted master index lives in S_ARID's MSB
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ar_state   <= AR_IDLE;
      last_grant <= 1'b1;
      S_ARID     <= '0;
      S_ARADDR   <= '0;
      S_ARLEN    <= '0;
      S_ARSIZE   <= '0;
      S_ARBURST  <= '0;
      S_ARLOCK   <= '0;
      S_ARCACHE  <= '0;
      S_ARPROT   <= '0;
    end else if (ar_state == AR_IDLE) begin
      if (grant_any) begin
        ar_state  <= AR_SEND;
        S_ARID    <= {grant_m, pick_id};
        S_ARADDR  <= pick_addr;
        S_ARLEN   <= pick_len;
        S_ARSIZE  <= pick_size;
        S_ARBURST <= pick_burst;
        S_ARLOCK  <= pick_lock;
        S_ARCACHE <= pick_cache;
        S_ARPROT  <= pick_prot;
      end
    end else if (S_ARREADY) begin
      ar_state   <= AR_IDLE;
      last_grant <= S_ARID[TAGW-1];
    end
  end

  assign sel = S_RID[TAGW-1];

`ifdef RD_ARB_ERRCHK_EN
  assign unexp = S_RVALID && (out_cnt[sel] == 3'd0);

  // Sticky unexpected-R flag, cleared only by reset
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)   err_unexp <= 1'b0;
    else if (unexp) err_unexp <= 1'b1;
  end
`else
  assign unexp     = 1'b0;
  assign err_unexp = 1'b0;
`endif

  // R routing by tag MSB; unexpected beats are hidden from masters and drained
  always_comb begin
    M0_RID    = S_RID[TAGW-2:0];
    M1_RID    = S_RID[TAGW-2:0];
    M0_RDATA  = S_RDATA;
    M1_RDATA  = S_RDATA;
    M0_RRESP  = S_RRESP;
    M1_RRESP  = S_RRESP;
    M0_RLAST  = S_RLAST;
    M1_RLAST  = S_RLAST;
    M0_RVALID = S_RVALID && !sel && !unexp;
    M1_RVALID = S_RVALID &&  sel && !unexp;
    S_RREADY  = unexp || (sel ? M1_RREADY : M0_RREADY);
  end

  assign r_done = S_RVALID && S_RREADY && S_RLAST;

  // Per-master increment/decrement requests; decrement saturates at zero
  always_comb begin
    inc = '0;
    dec = '0;
    inc[S_ARID[TAGW-1]] = ar_acc;
    dec[sel]            = r_done && (out_cnt[sel] != 3'd0);
  end

  // Outstanding-burst counters; same-master inc and dec cancel
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      out_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (inc[i] && !dec[i])      out_cnt[i] <= out_cnt[i] + 3'd1;
        else if (dec[i] && !inc[i]) out_cnt[i] <= out_cnt[i] - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter_2x1.sv
// Testbench for axi_rd_arbiter_2x1: random masters and slave, scoreboard of
// expected slave ARs plus a transaction-level model of grants, counters and
// R routing. Honours RD_ARB_ERRCHK_EN the same way as the design.
`timescale 1ns/1ps
module tb_axi_rd_arbiter_2x1;
  localparam int unsigned BW   = 32;
  localparam int unsigned TAGW = 2;
  localparam int unsigned MAXO = 2;

  typedef struct packed {
    logic [TAGW-2:0] id;
    logic [BW-1:0]   addr;
    logic [3:0]      len;
    logic [1:0]      size;
    logic [1:0]      burst;
    logic [1:0]      lock;
    logic [3:0]      cache;
    logic [2:0]      prot;
  } ar_t;
  typedef struct packed { logic m; ar_t p; } sar_t;
  typedef struct packed { logic [TAGW-1:0] tag; logic [3:0] len; } burst_t;

  logic ACLK = 1'b0;
  logic ARESETn;
  ar_t  m_ar [2];
  logic m_arvalid [2];
  logic m_arready [2];
  logic [TAGW-1:0] S_ARID;
  logic [BW-1:0]   S_ARADDR;
  logic [3:0]      S_ARLEN, S_ARCACHE;
  logic [1:0]      S_ARSIZE, S_ARBURST, S_ARLOCK;
  logic [2:0]      S_ARPROT;
  logic            S_ARVALID, S_ARREADY;
  logic [TAGW-1:0] S_RID;
  logic [BW-1:0]   S_RDATA;
  logic [1:0]      S_RRESP;
  logic            S_RLAST, S_RVALID, S_RREADY;
  logic [TAGW-2:0] m_rid [2];
  logic [BW-1:0]   m_rdata [2];
  logic [1:0]      m_rresp [2];
  logic            m_rlast [2], m_rvalid [2], m_rready [2];
  logic            err_unexp;

  axi_rd_arbiter_2x1 #(.BusWidth(BW), .TAGW(TAGW), .MAX_OUT(MAXO)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .M0_ARID(m_ar[0].id), .M0_ARADDR(m_ar[0].addr), .M0_ARLEN(m_ar[0].len),
    .M0_ARSIZE(m_ar[0].size), .M0_ARBURST(m_ar[0].burst), .M0_ARLOCK(m_ar[0].lock),
    .M0_ARCACHE(m_ar[0].cache), .M0_ARPROT(m_ar[0].prot),
    .M0_ARVALID(m_arvalid[0]), .M0_ARREADY(m_arready[0]),
    .M1_ARID(m_ar[1].id), .M1_ARADDR(m_ar[1].addr), .M1_ARLEN(m_ar[1].len),
    .M1_ARSIZE(m_ar[1].size), .M1_ARBURST(m_ar[1].burst), .M1_ARLOCK(m_ar[1].lock),
    .M1_ARCACHE(m_ar[1].cache), .M1_ARPROT(m_ar[1].prot),
    .M1_ARVALID(m_arvalid[1]), .M1_ARREADY(m_arready[1]),
    .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARSIZE(S_ARSIZE),
    .S_ARBURST(S_ARBURST), .S_ARLOCK(S_ARLOCK), .S_ARCACHE(S_ARCACHE), .S_ARPROT(S_ARPROT),
    .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
    .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .M0_RID(m_rid[0]), .M0_RDATA(m_rdata[0]), .M0_RRESP(m_rresp[0]), .M0_RLAST(m_rlast[0]),
    .M0_RVALID(m_rvalid[0]), .M0_RREADY(m_rready[0]),
    .M1_RID(m_rid[1]), .M1_RDATA(m_rdata[1]), .M1_RRESP(m_rresp[1]), .M1_RLAST(m_rlast[1]),
    .M1_RVALID(m_rvalid[1]), .M1_RREADY(m_rready[1]),
    .err_unexp(err_unexp)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int failures = 0;

  // Reference model: one AR slot toward the slave at a time, per-master burst counts
  bit   pend;
  int   cnt [2];
  int   lastg;
  bit   err_m;
  sar_t exp_q [$];
  int   rr_seq [$];

  // Bench-side slave and stimulus knobs
  burst_t      sq [$];
  int          beat;
  int unsigned p_ar [2];
  int unsigned p_sar, p_rv, p_rr;
  bit          fix0, inj;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: evaluated mid-cycle, predicts and checks, then advances the model to the next edge
  always @(negedge ACLK) begin
    bit   sel, unexp, exp_srr, dec, newpend, e0, e1;
    int   w, inc_m;
    sar_t f;
    if (ARESETn === 1'b1) begin
      sel   = S_RID[TAGW-1];
      unexp = 1'b0;
`ifdef RD_ARB_ERRCHK_EN
      unexp = S_RVALID && (cnt[sel] == 0);
`endif
      exp_srr = unexp || (sel ? m_rready[1] : m_rready[0]);
      chk("M0_RVALID", 64'(m_rvalid[0]), 64'(S_RVALID && sel == 1'b0 && !unexp));
      chk("M1_RVALID", 64'(m_rvalid[1]), 64'(S_RVALID && sel == 1'b1 && !unexp));
      chk("S_RREADY", 64'(S_RREADY), 64'(exp_srr));
      chk("R_side", 64'({m_rid[0], m_rid[1], m_rlast[0], m_rlast[1], m_rresp[0], m_rresp[1]}),
          64'({S_RID[0], S_RID[0], S_RLAST, S_RLAST, S_RRESP, S_RRESP}));
      chk("R_data", 64'({m_rdata[0], m_rdata[1]}), {S_RDATA, S_RDATA});
      chk("err_unexp", 64'(err_unexp), 64'(err_m));
      dec = S_RVALID && exp_srr && S_RLAST && (cnt[sel] > 0);

      chk("S_ARVALID", 64'(S_ARVALID), 64'(pend));
      newpend = pend;
      inc_m   = -1;
      if (!pend) begin
        e0 = m_arvalid[0] && (cnt[0] < int'(MAXO));
        e1 = m_arvalid[1] && (cnt[1] < int'(MAXO));
        w  = -1;
        if (e0 && e1) w = 1 - lastg;
        else if (e0)  w = 0;
        else if (e1)  w = 1;
        chk("M0_ARREADY", 64'(m_arready[0]), 64'(w == 0));
        chk("M1_ARREADY", 64'(m_arready[1]), 64'(w == 1));
        if (w >= 0) begin
          f.m = w[0];
          f.p = m_ar[w];
          exp_q.push_back(f);
          newpend = 1'b1;
        end
      end else begin
        chk("ARREADY_in_send", 64'({m_arready[0], m_arready[1]}), 64'(0));
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_empty: actual=S_ARVALID high required=no pending AR at %0t", $time);
        end else begin
          chk("S_AR_payload",
              64'({S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST, S_ARLOCK, S_ARCACHE, S_ARPROT}),
              64'(exp_q[0]));
          if (S_ARREADY) begin
            f = exp_q.pop_front();
            inc_m = int'(f.m);
            rr_seq.push_back(int'(f.m));
            newpend = 1'b0;
          end
        end
      end
      if (dec) cnt[sel] = cnt[sel] - 1;
      if (inc_m >= 0) begin
        cnt[inc_m] = cnt[inc_m] + 1;
        lastg = inc_m;
      end
      pend = newpend;
      if (unexp) err_m = 1'b1;
    end
  end

  function automatic ar_t rand_ar();
    ar_t a;
    a.id    = TAGW'($urandom_range(1));
    a.addr  = $urandom;
    a.len   = 4'($urandom_range(3));
    a.size  = 2'($urandom_range(3));
    a.burst = 2'($urandom_range(3));
    a.lock  = 2'($urandom_range(3));
    a.cache = 4'($urandom_range(15));
    a.prot  = 3'($urandom_range(7));
    return a;
  endfunction

  // One clock of stimulus: observe handshakes mid-cycle, drive new inputs just after the edge
  task automatic step();
    bit     mf [2];
    bit     arf, rf, rl;
    burst_t nb;
    ar_t    fx;
    @(negedge ACLK);
    mf[0] = m_arvalid[0] && m_arready[0];
    mf[1] = m_arvalid[1] && m_arready[1];
    arf   = S_ARVALID && S_ARREADY;
    nb.tag = S_ARID;
    nb.len = S_ARLEN;
    rf    = S_RVALID && S_RREADY;
    rl    = S_RLAST;
    @(posedge ACLK);
    #1;
    if (arf) sq.push_back(nb);
    if (rf) begin
      if (rl) begin
        if (sq.size() > 0) void'(sq.pop_front());
        beat = 0;
      end else beat++;
    end
    for (int x = 0; x < 2; x++) begin
      if (mf[x]) m_arvalid[x] = 1'b0;
      if (!m_arvalid[x] && $urandom_range(99) < p_ar[x]) begin
        m_ar[x] = rand_ar();
        if (x == 0 && fix0) begin
          fx = '0;
          fx.id = 1'b1;
          fx.addr = 32'h100;
          fx.len = 4'd3;
          m_ar[0] = fx;
        end
        m_arvalid[x] = 1'b1;
      end
      m_rready[x] = ($urandom_range(99) < p_rr);
    end
    S_ARREADY = ($urandom_range(99) < p_sar);
    if (!(S_RVALID && !rf)) begin
      S_RVALID = 1'b0;
      if (sq.size() > 0 && $urandom_range(99) < p_rv) begin
        S_RVALID = 1'b1;
        S_RID    = sq[0].tag;
        S_RLAST  = (beat == int'(sq[0].len));
        S_RDATA  = $urandom;
        S_RRESP  = 2'($urandom_range(3));
      end
    end
    if (inj) begin
      S_RVALID    = 1'b1;
      S_RID       = 2'b11;
      S_RLAST     = 1'b1;
      S_RDATA     = $urandom;
      m_rready[1] = 1'b0;
      inj = 1'b0;
    end
  endtask

  // Asynchronous reset away from the clock edge; checks outputs while held
  task automatic do_reset(input int ncyc);
    @(posedge ACLK);
    #3;
    ARESETn = 1'b0;
    #1;
    chk("rst_S_ARVALID", 64'(S_ARVALID), 64'(0));
    chk("rst_ARREADY", 64'({m_arready[0], m_arready[1]}), 64'(0));
    chk("rst_err_unexp", 64'(err_unexp), 64'(0));
    pend = 1'b0;
    cnt[0] = 0;
    cnt[1] = 0;
    lastg = 1;
    err_m = 1'b0;
    exp_q.delete();
    rr_seq.delete();
    sq.delete();
    beat = 0;
    S_RVALID = 1'b0;
    repeat (ncyc) @(posedge ACLK);
    #3;
    ARESETn = 1'b1;
  endtask

  task automatic quiet();
    p_ar[0] = 0; p_ar[1] = 0; p_sar = 100; p_rv = 100; p_rr = 100;
    repeat (40) step();
  endtask

  initial begin
    ARESETn = 1'b0;
    m_ar[0] = rand_ar();
    m_ar[1] = rand_ar();
    m_arvalid[0] = 1'b1;
    m_arvalid[1] = 1'b1;
    m_rready[0] = 1'b0;
    m_rready[1] = 1'b0;
    S_ARREADY = 1'b0;
    S_RVALID = 1'b0;
    S_RID = '0;
    S_RDATA = '0;
    S_RRESP = '0;
    S_RLAST = 1'b0;
    beat = 0;
    fix0 = 1'b0;
    inj = 1'b0;
    // Round-robin from reset, then throttle at MAXO with no R return
    p_ar[0] = 100; p_ar[1] = 100; p_sar = 100; p_rv = 0; p_rr = 0;
    do_reset(3);
    repeat (20) step();
    if (rr_seq.size() < 4) begin
      failures++;
      $display("FAIL rr_count: actual=%0d required>=4", rr_seq.size());
    end else begin
      chk("rr_seq0", 64'(rr_seq[0]), 64'(0));
      chk("rr_seq1", 64'(rr_seq[1]), 64'(1));
      chk("rr_seq2", 64'(rr_seq[2]), 64'(0));
      chk("rr_seq3", 64'(rr_seq[3]), 64'(1));
    end
    chk("throttled_total", 64'(rr_seq.size()), 64'(2 * MAXO));
    // Release the throttle by returning bursts
    p_rv = 100; p_rr = 100;
    repeat (30) step();
    // Slave AR backpressure
    p_sar = 0;
    repeat (8) step();
    // Random traffic, mid-run reset, more random traffic
    p_ar[0] = 60; p_ar[1] = 60; p_sar = 50; p_rv = 60; p_rr = 70;
    repeat (800) step();
    do_reset(2);
    repeat (800) step();
    // Single-master M0 with fixed ID/ADDR/LEN
    quiet();
    fix0 = 1'b1;
    p_ar[0] = 100; p_sar = 70;
    repeat (40) step();
    fix0 = 1'b0;
    quiet();
`ifdef RD_ARB_ERRCHK_EN
    inj = 1'b1;
    repeat (6) step();
    chk("err_sticky", 64'(err_unexp), 64'(1));
    do_reset(2);
    repeat (4) step();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter_2x1.md
# axi_rd_arbiter_2x1

Two-master-to-one-slave AXI read interconnect sitting directly upstream of the read slave. Arbitrates AR requests from master 0 and master 1 round-robin and forwards them to the slave through a registered AR stage. The master index is prefixed onto ARID, forming the slave's `TAGW`-bit tag. R beats are routed back to the owning master by the tag's MSB. Per-master outstanding-burst counters throttle each master.

## Interface
- `BusWidth`, 32, address/data width
- `TAGW`, 2, slave-side tag width; master-side ID width is `TAGW-1`
- `MAX_OUT`, 4, maximum outstanding read bursts per master (1..7)
- `ACLK` in 1: clock; all state updates on rising edge
- `ARESETn` in 1: reset, asynchronous, active-low
- `M0_ARID`, `M1_ARID` in `TAGW-1`: master AR IDs
- `M0_/M1_ARADDR` in `BusWidth`; `ARLEN` in 4; `ARSIZE` in 2; `ARBURST` in 2; `ARLOCK` in 2; `ARCACHE` in 4; `ARPROT` in 3: master AR payload
- `M0_/M1_ARVALID` in 1; `M0_/M1_ARREADY` out 1: master AR handshake
- `S_ARID` out `TAGW`; `S_ARADDR`/`ARLEN`/`ARSIZE`/`ARBURST`/`ARLOCK`/`ARCACHE`/`ARPROT` out (same widths): slave AR payload
- `S_ARVALID` out 1; `S_ARREADY` in 1: slave AR handshake
- `S_RID` in `TAGW`; `S_RDATA` in `BusWidth`; `S_RRESP` in 2; `S_RLAST` in 1; `S_RVALID` in 1; `S_RREADY` out 1: slave R channel
- `M0_/M1_RID` out `TAGW-1`; `RDATA` out `BusWidth`; `RRESP` out 2; `RLAST` out 1; `RVALID` out 1; `RREADY` in 1: master R channels
- `err_unexp` out 1: sticky unexpected-R flag (see Configuration)

## Operation
- **State reset.** AR FSM in `AR_IDLE`; `last_grant=1`, so M0 wins the first tie. `out_cnt[0]` and `out_cnt[1]` (3 bits) are 0. All AR payload registers are 0. `err_unexp=0`.
- **Output reset values.** `M0_ARREADY=0`, `M1_ARREADY=0`, `S_ARVALID=0`.
- **Eligibility.** Master x is eligible when `Mx_ARVALID && out_cnt[x] < MAX_OUT`.
- **`AR_IDLE`.**
  - If any master is eligible, pick one. With both eligible, pick the one that is not `last_grant`.
  - Pulse `Mg_ARREADY=1` for exactly that cycle (the master handshake).
  - Latch the payload, setting `S_ARID={g, Mg_ARID}`. Store g and go to `AR_SEND`.
  - If no master is eligible, stay in `AR_IDLE` with both ARREADYs at 0.
- **`AR_SEND`.**
  - Hold `S_ARVALID=1` with a stable payload until `S_ARREADY`.
  - On `S_ARVALID && S_ARREADY`: `out_cnt[g]+=1`, `last_grant=g`, go to `AR_IDLE`, and drop `S_ARVALID` the next cycle.
  - Both ARREADYs are 0 in this state.
- **R routing (combinational).**
  - `sel=S_RID[TAGW-1]`.
  - `Mx_RVALID = S_RVALID && sel==x`.
  - RID, RDATA, RRESP and RLAST drive both masters, with `Mx_RID=S_RID[TAGW-2:0]`.
  - `S_RREADY = sel ? M1_RREADY : M0_RREADY`.
- **Burst completion.** `S_RVALID && S_RREADY && S_RLAST` decrements `out_cnt[sel]`.
- **Simultaneous events.**
  - AR accept and R-last completion on the same master in the same cycle leave `out_cnt` unchanged.
  - AR accept and R-last completion on different masters update both counters independently.
- **Counter limits.** `out_cnt` never exceeds `MAX_OUT` and never goes below 0.
- **Reset mid-operation.** Drops `S_ARVALID` asynchronously, discards the pending AR and clears the counters. In-flight slave R beats are then handled as unexpected.

## Timing
- **AR latency.** Master handshake at edge N; `S_ARVALID` is high from N+1.
- **AR throughput.** At least 2 cycles per AR (one `AR_IDLE`, one or more `AR_SEND`).
- **R path.** Zero latency and no buffering.
- **Handshake rule.** No combinational path from `S_ARREADY` to any master ARREADY.
- **Arbitration.** A master whose ARVALID stays asserted is granted within 2 AR slots.

## Configuration
- **Macro.** `RD_ARB_ERRCHK_EN`.
- **Defined.** When `S_RVALID` and `out_cnt[sel]==0`:
  - suppress `Mx_RVALID` for that master;
  - force `S_RREADY=1` to drain the beat;
  - set `err_unexp=1` (sticky, cleared only by reset).
- **Undefined.** No check is made, `err_unexp` is tied to 0, and the decrement saturates at 0.

## Test plan
- **Single master M0.** M0 issues ARID=1, ARADDR=0x100, ARLEN=3. Expect `M0_ARREADY` for 1 cycle, then `S_ARVALID` the next cycle with `S_ARID=2'b01` and ARADDR=0x100. After the slave returns 4 beats with `S_RID=2'b01` and RLAST on beat 4: `M0_RVALID` follows each beat, `M1_RVALID` stays 0, and `out_cnt[0]` goes 0→1→0.
- **Round-robin.** Both masters hold ARVALID continuously and the slave ARREADY is 1. Expect `S_ARID[1]` sequence 0,1,0,1 from reset.
- **Throttle.** `MAX_OUT=2`; M1 issues 3 ARs with no R return. Expect the third `M1_ARREADY` held at 0. After one R-last with `S_RID=2'b10`, the third AR is accepted.
- **Backpressure.** `S_ARREADY` held at 0 for 5 cycles. Expect `S_ARVALID` and the payload stable for all 5 cycles, and no master ARREADY asserted.
- **Simultaneous accept and complete.** Same-cycle M0 AR accept and M0 R-last completion leave `out_cnt[0]` unchanged.
- **Unexpected R (`RD_ARB_ERRCHK_EN` defined).** A beat with `S_RID=2'b11` while `out_cnt[1]=0` gives `M1_RVALID=0`, `S_RREADY=1` and `err_unexp=1` held until `ARESETn` is low.
